// File: rtl/io_mem_pkg.sv
// Shared constants and types for the io_memory block.
package io_mem_pkg;

    localparam int unsigned MEM_BYTES     = 4096;
    localparam int unsigned ADDR_BITS     = 12;
    localparam logic [ADDR_BITS-1:0] DOORBELL_ADDR = 12'hFFC;
    localparam int unsigned BYTE_W        = 8;
    localparam int unsigned WORD_W        = 32;
    localparam int unsigned WORD_BYTES    = WORD_W / BYTE_W;

    typedef logic [BYTE_W-1:0]    byte_t;
    typedef logic [WORD_W-1:0]    word_t;
    typedef logic [ADDR_BITS-1:0] addr_t;

endpackage

// File: rtl/io_intr_ctrl.sv
// Interrupt source: delayed one-shot timer plus doorbell, cleared by CPU ack.
// Define IO_INTR_PERIODIC_EN to re-arm the timer on every acknowledge.
module io_intr_ctrl #(
    parameter int unsigned INTR_DELAY = 200
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set_i,
    input  logic ack_i,
    output logic pending_o
);

    localparam int unsigned CNT_W = (INTR_DELAY > 0) ? $clog2(INTR_DELAY + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(INTR_DELAY);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             armed_q, armed_d;
    logic             pending_q, pending_d;
    logic             fire;

    always_comb begin
        cnt_d     = cnt_q;
        armed_d   = armed_q;
        pending_d = pending_q;
        fire      = armed_q && (cnt_q == CNT_W'(1));

        if (armed_q && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
        if (fire) begin
            armed_d = 1'b0;
        end
`ifdef IO_INTR_PERIODIC_EN
        if (ack_i) begin
            cnt_d   = CNT_INIT;
            armed_d = 1'b1;
        end
`endif
        // A new request in the same cycle as an ack must not be lost.
        if (set_i || fire) begin
            pending_d = 1'b1;
        end else if (ack_i) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= CNT_INIT;
            armed_q   <= 1'b1;
            pending_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            armed_q   <= armed_d;
            pending_q <= pending_d;
        end
    end

    assign pending_o = pending_q;

endmodule

// File: rtl/io_memory.sv
// Memory-mapped I/O block: big-endian byte store with word access and an interrupt source.
// Build option IO_INTR_PERIODIC_EN makes the timer interrupt periodic (see io_intr_ctrl).
module io_memory #(
    parameter int unsigned MEM_BYTES     = io_mem_pkg::MEM_BYTES,
    parameter int unsigned INTR_DELAY    = 200,
    parameter logic [11:0] DOORBELL_ADDR = io_mem_pkg::DOORBELL_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        wr,
    input  logic        rd,
    input  logic [31:0] Addr,
    input  logic [31:0] IO_In,
    output logic [31:0] IO_Out,
    output logic        int_r,
    input  logic        int_ack
);

    import io_mem_pkg::*;

    localparam int unsigned IDX_W = $clog2(MEM_BYTES);

    addr_t            a;
    logic [IDX_W-1:0] idx [WORD_BYTES];
    byte_t            mem_q [MEM_BYTES];
    word_t            rd_word;
    logic             wr_en;
    logic             rd_en;
    logic             doorbell;

    assign a     = Addr[ADDR_BITS-1:0];
    assign wr_en = cs && wr;
    assign rd_en = cs && rd;

    // Byte lanes wrap modulo the array size, so unaligned words straddle 0xFFF/0x000.
    always_comb begin
        for (int unsigned i = 0; i < WORD_BYTES; i++) begin
            idx[i] = IDX_W'(a + ADDR_BITS'(i));
        end
    end

    always_comb begin
        rd_word = '0;
        for (int unsigned i = 0; i < WORD_BYTES; i++) begin
            rd_word[WORD_W-1-i*BYTE_W -: BYTE_W] = mem_q[idx[i]];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned i = 0; i < WORD_BYTES; i++) begin
                mem_q[idx[i]] <= IO_In[WORD_W-1-i*BYTE_W -: BYTE_W];
            end
        end
    end

    assign IO_Out   = rd_en ? rd_word : 'z;
    assign doorbell = wr_en && (a == DOORBELL_ADDR) && IO_In[0];

    io_intr_ctrl #(
        .INTR_DELAY(INTR_DELAY)
    ) u_intr (
        .clk      (clk),
        .rst_n    (reset),
        .set_i    (doorbell),
        .ack_i    (int_ack),
        .pending_o(int_r)
    );

endmodule

// File: tb/tb_io_memory.sv
// Self-checking bench for io_memory: directed cases then random traffic vs a reference model.
module tb_io_memory;

    localparam int unsigned DELAY = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        cs, wr, rd, int_ack;
    logic [31:0] addr, io_in;
    wire  [31:0] io_out;
    logic        int_r;

    always #5 clk = ~clk;

    io_memory #(
        .MEM_BYTES    (4096),
        .INTR_DELAY   (DELAY),
        .DOORBELL_ADDR(12'hFFC)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .cs     (cs),
        .wr     (wr),
        .rd     (rd),
        .Addr   (addr),
        .IO_In  (io_in),
        .IO_Out (io_out),
        .int_r  (int_r),
        .int_ack(int_ack)
    );

    logic [7:0] m_mem   [4096];
    bit         m_valid [4096];
    bit         m_pend;
    int         edge_n;
    int         fire_at;
    int         n_pass   = 0;
    int         n_checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic bit model_word(input logic [31:0] a, output logic [31:0] w);
        bit ok;
        int unsigned b;
        ok = 1'b1;
        w  = '0;
        for (int i = 0; i < 4; i++) begin
            b  = (int'(a[11:0]) + i) % 4096;
            w  = {w[23:0], m_mem[b]};
            ok = ok & m_valid[b];
        end
        return ok;
    endfunction

    // One bus cycle: drive, check mid-cycle, clock, then advance the model.
    task automatic do_cycle(input bit c, input bit w, input bit r, input bit ack,
                            input logic [31:0] a, input logic [31:0] d,
                            input bit has_want, input logic [31:0] want);
        logic [31:0] mw;
        bit          set;
        int unsigned b;
        cs = c; wr = w; rd = r; int_ack = ack; addr = a; io_in = d;
        #1;
        if (c && r) begin
            if (model_word(a, mw)) check("rd_model", io_out, mw);
            if (has_want) check("rd_const", io_out, want);
        end else begin
            check("hiz", io_out, 32'hz);
        end
        check("int_r", {31'b0, int_r}, {31'b0, m_pend});
        @(posedge clk);
        edge_n++;
        set = (c && w && (a[11:0] == 12'hFFC) && d[0]);
        if (fire_at >= 0 && edge_n == fire_at) begin
            set     = 1'b1;
            fire_at = -1;
        end
`ifdef IO_INTR_PERIODIC_EN
        if (ack) fire_at = edge_n + int'(DELAY);
`endif
        if (set) m_pend = 1'b1;
        else if (ack) m_pend = 1'b0;
        if (c && w) begin
            for (int i = 0; i < 4; i++) begin
                b          = (int'(a[11:0]) + i) % 4096;
                m_mem[b]   = d[31-8*i -: 8];
                m_valid[b] = 1'b1;
            end
        end
        #1;
    endtask

    task automatic idle(input bit ack);
        do_cycle(1'b0, 1'b0, 1'b0, ack, 32'h0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic wr_word(input logic [31:0] a, input logic [31:0] d);
        do_cycle(1'b1, 1'b1, 1'b0, 1'b0, a, d, 1'b0, 32'h0);
    endtask

    task automatic rd_word(input logic [31:0] a, input logic [31:0] want);
        do_cycle(1'b1, 1'b0, 1'b1, 1'b0, a, 32'h0, 1'b1, want);
    endtask

    task automatic release_reset();
        #1 reset = 1'b1;
        edge_n  = 0;
        fire_at = int'(DELAY);
    endtask

    initial begin
        logic [31:0] ra;
        bit          c, w, r, k;
        reset = 1'b0; cs = 0; wr = 0; rd = 0; int_ack = 0; addr = '0; io_in = '0;
        m_pend  = 1'b0;
        fire_at = -1;
        edge_n  = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_int_r", {31'b0, int_r}, 32'h0);
        release_reset();

        // Timer fires exactly DELAY edges after release.
        repeat (DELAY - 1) idle(1'b0);
        check("timer_early", {31'b0, int_r}, 32'h0);
        idle(1'b0);
        check("timer_rise", {31'b0, int_r}, 32'h1);
        idle(1'b1);
        check("ack_clear", {31'b0, int_r}, 32'h0);
        repeat (DELAY + 5) idle(1'b0);
`ifdef IO_INTR_PERIODIC_EN
        check("periodic_again", {31'b0, int_r}, 32'h1);
        idle(1'b1);
`else
        check("oneshot_quiet", {31'b0, int_r}, 32'h0);
`endif

        // Byte order, unaligned access, and wrap at the top of the array.
        wr_word(32'h0000_0010, 32'h1234_5678);
        wr_word(32'h0000_0014, 32'h9ABC_DEF0);
        rd_word(32'h0000_0010, 32'h1234_5678);
        rd_word(32'hFFFF_F011, 32'h3456_789A);
        wr_word(32'h0000_0020, 32'hCAFE_F00D);
        do_cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0020, 32'hDEAD_BEEF, 1'b0, 32'h0);
        do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0020, 32'h0, 1'b0, 32'h0);
        rd_word(32'h0000_0020, 32'hCAFE_F00D);
        wr_word(32'h0000_0FFE, 32'hAABB_CCDD);
        wr_word(32'h0000_0002, 32'h1122_3344);
        rd_word(32'h0000_0FFE, 32'hAABB_CCDD);
        rd_word(32'h0000_0000, 32'hCCDD_1122);
        // Read during write shows the old contents.
        do_cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0010, 32'h5555_AAAA, 1'b1, 32'h1234_5678);
        rd_word(32'h0000_0010, 32'h5555_AAAA);

        // Doorbell set, non-set data, and set/ack collision.
        wr_word(32'h0000_0FFC, 32'h0000_0001);
        check("door_set", {31'b0, int_r}, 32'h1);
        idle(1'b1);
        wr_word(32'h0000_0FFC, 32'h0000_0000);
        check("door_zero", {31'b0, int_r}, 32'h0);
        wr_word(32'h0000_0FFC, 32'h0000_0001);
        do_cycle(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0FFC, 32'h0000_0001, 1'b0, 32'h0);
        check("set_beats_ack", {31'b0, int_r}, 32'h1);

        // Asynchronous reset clears the request without a clock edge.
        #2 reset = 1'b0;
        #1;
        check("async_rst", {31'b0, int_r}, 32'h0);
        m_pend  = 1'b0;
        fire_at = -1;
        @(posedge clk);
        release_reset();

        // Random traffic concentrated near both ends of the array.
        for (int n = 0; n < 3000; n++) begin
            c  = ($urandom % 4) != 0;
            w  = $urandom % 2;
            r  = $urandom % 2;
            k  = ($urandom % 6) == 0;
            ra = $urandom;
            if (($urandom % 8) == 0) ra[11:0] = 12'hFFC;
            else ra[11:0] = 12'($urandom_range(0, 63)) + ((($urandom % 2) != 0) ? 12'hFC0 : 12'h000);
            do_cycle(c, w, r, k, ra, $urandom, 1'b0, 32'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/io_memory.md
Name: io_memory

Overview:
- Memory-mapped I/O block on the CPU's shared data bus, in parallel with the data memory; selected by its own chip select.
- Contains a 4 KiB byte-addressable, big-endian store for 32-bit word accesses.
- Contains an interrupt source with a CPU acknowledge handshake. The source fires once after a fixed delay from reset, or on a software doorbell write.

Parameters:
- MEM_BYTES, 4096, storage size in bytes; power of two.
- INTR_DELAY, 200, clock cycles after reset release before the timer interrupt is raised; 0 disables the timer.
- DOORBELL_ADDR, 12'hFFC, byte address whose write with data bit0=1 requests an interrupt.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- cs  input  1  chip select.
- wr  input  1  write enable, qualified by cs.
- rd  input  1  read enable, qualified by cs.
- Addr  input  32  byte address; only Addr[11:0] used, upper bits ignored.
- IO_In  input  32  write data.
- IO_Out  output  32  read data; high-impedance when not reading (shared bus).
- int_r  output  1  interrupt request to CPU, level.
- int_ack  input  1  interrupt acknowledge from CPU.

Behaviour:
- Address a = Addr[11:0]. Word bytes are a, a+1, a+2, a+3, each taken modulo MEM_BYTES (wrap at 0xFFF to 0x000). No alignment check.
- Read:
  - Combinational, zero latency.
  - IO_Out = {M[a],M[a+1],M[a+2],M[a+3]} when cs&rd, else 32'hz.
  - cs&rd&wr together: read shows pre-write contents; write commits at the edge.
- Write:
  - Synchronous on posedge clk when cs&wr.
  - M[a]=IO_In[31:24], M[a+1]=IO_In[23:16], M[a+2]=IO_In[15:8], M[a+3]=IO_In[7:0].
  - wr/rd with cs=0 have no effect.
- Memory array is not cleared by reset; contents are undefined until written or preloaded by simulation file load.
- Interrupt controller:
  - State: pending (drives int_r) and a down-counter cnt.
  - On reset assert: pending=0, int_r=0, cnt=INTR_DELAY, armed=1.
  - Each posedge while armed and cnt!=0: cnt decrements.
  - When cnt reaches 1→0 while armed: pending set, armed cleared (one-shot).
  - Doorbell: cs&wr with a==DOORBELL_ADDR and IO_In[0]=1 sets pending at that edge. The data is also stored in memory.
  - Acknowledge: int_ack=1 sampled at posedge clears pending.
  - Set and ack in the same cycle: set wins, int_r stays 1.
  - int_r is registered, 1 cycle after the triggering edge condition.
  - Repeated doorbells while pending are idempotent (no counting).
  - Reset mid-operation: pending cleared immediately (async); timer restarts from INTR_DELAY after release.

Optional Feature:
- Macro IO_INTR_PERIODIC_EN.
- Defined: on each acknowledge, cnt reloads INTR_DELAY and armed=1, giving a periodic interrupt every INTR_DELAY cycles after each ack.
- Undefined: the timer is one-shot per reset. The doorbell works identically in both builds.

Decomposition:
- Package io_mem_pkg: MEM_BYTES, ADDR_BITS (12), DOORBELL_ADDR, word/byte width constants.
- One sub-module io_intr_ctrl: counter, armed, pending, set/ack priority, periodic reload. Memory array and bus decode stay in io_memory.

Test Plan:
- Write 0x12345678 at 0x010, read 0x010 → IO_Out=0x12345678; byte check: read 0x011 → 0x345678xx with xx = M[0x014].
- cs=0 or rd=0 → IO_Out=32'hz; cs=0 & wr=1 to 0x020 → later read of 0x020 unchanged.
- Wrap: write 0xAABBCCDD at 0xFFE → M[0xFFE]=AA, M[0xFFF]=BB, M[0x000]=CC, M[0x001]=DD.
- INTR_DELAY=10: reset released → int_r rises exactly 10 cycles later; int_ack pulse → int_r low next edge; no further interrupt without the macro; with IO_INTR_PERIODIC_EN, int_r rises again 10 cycles after ack.
- Doorbell: write 0x00000001 to 0xFFC → int_r=1 next cycle; write 0x00000000 → no interrupt; doorbell and int_ack in the same cycle → int_r remains 1.
- Assert reset low while int_r=1 → int_r=0 immediately, without a clock edge.
